// File: rtl/fetch_sequencer_if.sv
// Instruction-memory bus: request/grant handshake plus in-order read response.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;

    // Fetch side drives requests and receives grants and read data.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side accepts requests and returns read data.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding memory request at a time,
// a 2-entry {pc, instruction} buffer toward the consumer, and a redirect
// (pcSrc) that flushes the buffer and drops any response still in flight.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'h0001
) (
    input  logic               inp_clk,
    input  logic               inp_rst_n,
    input  logic               pcSrc,
    input  logic [15:0]        branchTarget_address,
    fetch_sequencer_if.master  imem,
    output logic [15:0]        instruction,
    output logic [15:0]        instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [15:0]        pc_address
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc_next;
    logic [15:0] req_addr;      // address of the request currently in flight
    logic        capture;       // request accepted this cycle
    logic        push;
    logic        pop;
    logic        flush;

    logic [15:0] fifo_pc    [2];
    logic [15:0] fifo_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    // Requests are masked while reset is held so the bus stays idle, and
    // a new request is only issued when the buffer has room for its data.
    assign imem.imem_req  = inp_rst_n && (state == FETCH) && (count < 2'd2);
    assign imem.imem_addr = pc_address;

    assign flush = pcSrc;
    assign pop   = instr_valid && instr_ready;

    // Next-state, next-PC and push decode for the fetch FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned and no latch is inferred.
        state_next = state;
        pc_next    = pc_address;
        capture    = 1'b0;
        push       = 1'b0;
        case (state)
            FETCH: begin
                if (imem.imem_req && imem.imem_gnt) begin
                    capture    = 1'b1;
                    state_next = pcSrc ? DISCARD : WAIT;
                    pc_next    = pc_address + PC_STEP;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    state_next = FETCH;
                    push       = !pcSrc;
                end else if (pcSrc) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (imem.imem_rvalid) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
        // A redirect always wins over the sequential increment.
        if (pcSrc) begin
            pc_next = branchTarget_address;
        end
    end

    // FSM state, fetch PC and in-flight request address registers.
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            state      <= FETCH;
            pc_address <= RESET_PC;
            req_addr   <= 16'h0000;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state      <= state_next;
            pc_address <= pc_next;
            if (capture) begin
                req_addr <= pc_address;
            end
        end
    end

    // Buffer pointers and occupancy; a flush overrides any push or pop.
    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Buffer storage write port.
    // NOTE: the storage array has no reset; the head outputs are masked by instr_valid instead.
    always_ff @(posedge inp_clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= req_addr;
            fifo_instr[wr_ptr] <= imem.imem_rdata;
        end
    end

    assign instr_valid = (count != 2'd0);
    assign instruction = instr_valid ? fifo_instr[rd_ptr] : 16'h0000;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 16'h0000;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus a
// hand-written reset-in-flight sequence.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        pc_src;
    logic [15:0] target;
    logic [15:0] instruction;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc_address;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC (16'h0000),
        .PC_STEP  (16'h0001)
    ) dut (
        .inp_clk              (clk),
        .inp_rst_n            (rst_n),
        .pcSrc                (pc_src),
        .branchTarget_address (target),
        .imem                 (bus.master),
        .instruction          (instruction),
        .instr_pc             (instr_pc),
        .instr_valid          (instr_valid),
        .instr_ready          (instr_ready),
        .pc_address           (pc_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: inputs driven at the falling edge, outputs checked 1 ns later.
    typedef struct {
        bit          rst;      // apply a fresh reset before this cycle
        logic        pcsrc;
        logic [15:0] tgt;
        logic        gnt;
        logic        rvalid;
        logic [15:0] rdata;
        logic        ready;
        logic        e_req;
        logic [15:0] e_pc;     // expected pc_address (and imem_addr when requesting)
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_ipc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input logic pcsrc, input logic [15:0] tgt,
                       input logic gnt, input logic rvalid, input logic [15:0] rdata,
                       input logic ready, input logic e_req, input logic [15:0] e_pc,
                       input logic e_valid, input logic [15:0] e_instr, input logic [15:0] e_ipc);
        vec_t v;
        v.rst = rst; v.pcsrc = pcsrc; v.tgt = tgt; v.gnt = gnt; v.rvalid = rvalid;
        v.rdata = rdata; v.ready = ready; v.e_req = e_req; v.e_pc = e_pc;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_ipc = e_ipc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        pc_src          = 1'b0;
        target          = 16'h0000;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 16'h0000;
        instr_ready     = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " req"},   {31'd0, bus.imem_req}, 32'd0);
        check({tag, " pc"},    {16'd0, pc_address},   32'h0000);
        check({tag, " valid"}, {31'd0, instr_valid},  32'd0);
        check({tag, " instr"}, {16'd0, instruction},  32'h0000);
        check({tag, " ipc"},   {16'd0, instr_pc},     32'h0000);
    endtask

    // Hold reset for two cycles, then release mid-high so the next cycle is cycle 1.
    task automatic do_reset(input string tag);
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_values(tag);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        pc_src          = v.pcsrc;
        target          = v.tgt;
        bus.imem_gnt    = v.gnt;
        bus.imem_rvalid = v.rvalid;
        bus.imem_rdata  = v.rdata;
        instr_ready     = v.ready;
        #1;
        check({tag, " req"},   {31'd0, bus.imem_req}, {31'd0, v.e_req});
        check({tag, " pc"},    {16'd0, pc_address},   {16'd0, v.e_pc});
        check({tag, " valid"}, {31'd0, instr_valid},  {31'd0, v.e_valid});
        if (v.e_req) begin
            check({tag, " addr"}, {16'd0, bus.imem_addr}, {16'd0, v.e_pc});
        end
        if (v.e_valid) begin
            check({tag, " instr"}, {16'd0, instruction}, {16'd0, v.e_instr});
            check({tag, " ipc"},   {16'd0, instr_pc},    {16'd0, v.e_ipc});
        end
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;

        //   rst pcs tgt       gnt rv rdata     rdy  req pc        val instr     ipc
        // Streaming, then a stalled grant and a late response.
        add(1, 0, 16'h0000, 1, 0, 16'h0000, 1,   1, 16'h0000, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 1, 1, 16'hA5A5, 1,   0, 16'h0001, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1,   1, 16'h0001, 1, 16'hA5A5, 16'h0000);
        add(0, 0, 16'h0000, 1, 1, 16'hA5A4, 1,   0, 16'h0002, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1,   1, 16'h0002, 1, 16'hA5A4, 16'h0001);
        add(0, 0, 16'h0000, 1, 1, 16'hA5A7, 1,   0, 16'h0003, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h0003, 1, 16'hA5A7, 16'h0002);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h0003, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1,   1, 16'h0003, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   0, 16'h0004, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 16'hA5A6, 1,   0, 16'h0004, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h0004, 1, 16'hA5A6, 16'h0003);

        // Backpressure: two entries fill the buffer, then push and pop in one cycle.
        add(1, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 16'h0000, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 16'hA5A5, 0,   0, 16'h0001, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 16'h0001, 1, 16'hA5A5, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 16'hA5A4, 0,   0, 16'h0002, 1, 16'hA5A5, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0002, 1, 16'hA5A5, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0002, 1, 16'hA5A5, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1,   0, 16'h0002, 1, 16'hA5A5, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 16'h0002, 1, 16'hA5A4, 16'h0001);
        add(0, 0, 16'h0000, 0, 1, 16'hA5A7, 1,   0, 16'h0003, 1, 16'hA5A4, 16'h0001);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h0003, 1, 16'hA5A7, 16'h0002);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h0003, 0, 16'h0000, 16'h0000);

        // Redirect while waiting: late response dropped, fetch restarts at 0x0040.
        add(1, 0, 16'h0000, 1, 0, 16'h0000, 1,   1, 16'h0000, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0040, 0, 0, 16'h0000, 1,   0, 16'h0001, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1,   0, 16'h0040, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 16'hDEAD, 1,   0, 16'h0040, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1,   1, 16'h0040, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 16'hA5E5, 1,   0, 16'h0041, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h0041, 1, 16'hA5E5, 16'h0040);

        // Redirect coinciding with a grant, with one entry buffered (flushed).
        add(1, 0, 16'h0000, 1, 0, 16'h0000, 0,   1, 16'h0000, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 16'hA5A5, 0,   0, 16'h0001, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0100, 1, 0, 16'h0000, 0,   1, 16'h0001, 1, 16'hA5A5, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0100, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 16'hBEEF, 0,   0, 16'h0100, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1,   1, 16'h0100, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 16'hA4A5, 1,   0, 16'h0101, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h0101, 1, 16'hA4A5, 16'h0100);

        // Ungranted redirect to 0xFFFF, wrap, redirect with rvalid, repeated redirect in DISCARD.
        add(1, 1, 16'hFFFF, 0, 0, 16'h0000, 1,   1, 16'h0000, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1,   1, 16'hFFFF, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 16'h5A5A, 1,   0, 16'h0000, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1,   1, 16'h0000, 1, 16'h5A5A, 16'hFFFF);
        add(0, 0, 16'h0000, 0, 1, 16'hA5A5, 1,   0, 16'h0001, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h0001, 1, 16'hA5A5, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1,   1, 16'h0001, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0200, 0, 1, 16'h1234, 1,   0, 16'h0002, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h0200, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1,   1, 16'h0200, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0300, 0, 0, 16'h0000, 1,   0, 16'h0201, 0, 16'h0000, 16'h0000);
        add(0, 1, 16'h0400, 0, 0, 16'h0000, 1,   0, 16'h0300, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 1, 16'h9999, 1,   0, 16'h0400, 0, 16'h0000, 16'h0000);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1,   1, 16'h0400, 0, 16'h0000, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset($sformatf("rst@v%0d", i));
            end
            apply(i, vecs[i]);
        end

        // Reset asserted while a request is in flight, then a stray response after release.
        do_reset("rst_mid");
        @(negedge clk);
        bus.imem_gnt = 1'b1;
        instr_ready  = 1'b1;
        #1;
        check("mid req", {31'd0, bus.imem_req}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("mid async");
        drive_idle();
        instr_ready = 1'b1;
        @(negedge clk);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 16'h7777;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        #1;
        check("post req",   {31'd0, bus.imem_req},  32'd1);
        check("post addr",  {16'd0, bus.imem_addr}, 32'h0000);
        check("post valid", {31'd0, instr_valid},   32'd0);
        bus.imem_gnt = 1'b1;
        @(negedge clk);
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 16'hA5A5;
        #1;
        check("post pc",    {16'd0, pc_address},    32'h0001);
        check("post valid2", {31'd0, instr_valid},  32'd0);
        @(negedge clk);
        bus.imem_rvalid = 1'b0;
        #1;
        check("post head valid", {31'd0, instr_valid}, 32'd1);
        check("post head ipc",   {16'd0, instr_pc},    32'h0000);
        check("post head instr", {16'd0, instruction}, 32'hA5A5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, meaning the first fetch address after reset.
REQ-002 Parameter PC_STEP, default 16'h0001, meaning the PC increment per instruction (word-addressed memory).
REQ-003 inp_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 inp_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 pcSrc  input  1  redirect request; sampled every cycle.
REQ-006 branchTarget_address  input  16  redirect target, valid when pcSrc=1.
REQ-007 imem_req  output  1  instruction-memory request valid.
REQ-008 imem_addr  output  16  request address.
REQ-009 imem_gnt  input  1  memory accepts the request this cycle (handshake completes when imem_req&imem_gnt).
REQ-010 imem_rvalid  input  1  read data valid for the oldest accepted request.
REQ-011 imem_rdata  input  16  read data.
REQ-012 instruction  output  16  head-of-buffer instruction word.
REQ-013 instr_pc  output  16  address of the head-of-buffer instruction.
REQ-014 instr_valid  output  1  buffer head valid.
REQ-015 instr_ready  input  1  consumer pops the head when instr_valid&instr_ready.
REQ-016 pc_address  output  16  current fetch PC (next address to request).

Function
REQ-017 The block SHALL hold a 2-entry FIFO of {pc,instruction} pairs; a single request SHALL be outstanding at most.
REQ-018 FSM states SHALL be FETCH, WAIT and DISCARD.
REQ-019 FETCH: imem_req=1 and imem_addr=pc_address iff (FIFO count + 0 in-flight) < 2; on imem_req&imem_gnt, go to WAIT and set pc_address <= pc_address+PC_STEP.
REQ-020 WAIT: imem_req=0; on imem_rvalid, push {addr of request, imem_rdata} and go to FETCH.
REQ-021 DISCARD: imem_req=0; on imem_rvalid, drop the data and go to FETCH.
REQ-022 A request issued in FETCH SHALL require count<2, guaranteeing the push in WAIT never overflows the FIFO.
REQ-023 The pushed entry SHALL be visible on instruction/instr_pc/instr_valid the cycle after imem_rvalid (registered, no bypass).
REQ-024 Minimum latency SHALL be: request cycle N (gnt same cycle), rvalid cycle N+1, instr_valid cycle N+2.
REQ-025 PC arithmetic SHALL be 16-bit modulo; 16'hFFFF + 1 wraps to 16'h0000 without error.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-027 pcSrc=1 SHALL, at that clock edge: flush the FIFO (count=0, instr_valid=0 next cycle), and set pc_address <= branchTarget_address.
REQ-028 pcSrc=1 in FETCH without imem_gnt: stay in FETCH; the unaccepted request is withdrawn and imem_addr shows the target next cycle.
REQ-029 pcSrc=1 in FETCH with imem_gnt in the same cycle: go to DISCARD (old request's data dropped); pc_address still becomes the target, not target+PC_STEP.
REQ-030 pcSrc=1 in WAIT without imem_rvalid: go to DISCARD.
REQ-031 pcSrc=1 in WAIT with imem_rvalid in the same cycle: data dropped, go to FETCH.
REQ-032 pcSrc=1 in DISCARD: stay in DISCARD (or FETCH if imem_rvalid that cycle), with pc_address updated to the newest target.
REQ-033 Flush SHALL take priority over a simultaneous pop or push.
REQ-034 imem_addr SHALL remain stable while imem_req=1 and imem_gnt=0, unless pcSrc=1.

Reset
REQ-035 While inp_rst_n=0: state=FETCH, pc_address=RESET_PC, FIFO empty, instr_valid=0, instruction=16'h0000, instr_pc=16'h0000, imem_req=0.
REQ-036 imem_req SHALL first assert in the first cycle after inp_rst_n deasserts.
REQ-037 Reset asserted mid-transaction SHALL abandon the in-flight request; any imem_rvalid after reset release with no accepted request SHALL be ignored.

Verification
REQ-038 Streaming: gnt=1 always, rvalid 1 cycle after gnt, instr_ready=1, rdata=addr^16'hA5A5 -> instr_pc sequence 0,1,2,...; instr_valid first high at cycle 3 after reset release.
REQ-039 Backpressure: instr_ready=0 -> exactly two entries (pc 0,1) buffered, imem_req stays 0; on instr_ready=1, pc 0 is delivered first and fetching resumes.
REQ-040 Redirect in WAIT: pcSrc=1 with target 16'h0040 while waiting -> the late rvalid data is dropped; next instr_pc=16'h0040.
REQ-041 Simultaneous pcSrc and imem_gnt in FETCH, target 16'h0100 -> DISCARD entered, old data dropped, next request addr 16'h0100.
REQ-042 Wrap: redirect to 16'hFFFF -> instr_pc 16'hFFFF then 16'h0000.
REQ-043 Reset mid-WAIT -> all outputs at reset values; first post-reset imem_addr=RESET_PC; a stray rvalid is ignored.
